// File: rtl/idex_queue.sv
// Decode-to-execute dispatch queue: circular buffer of decoded instructions that
// snoops the CDB so waiting operands pick up broadcast values before issue.
module idex_queue #(
    parameter int DEPTH  = 4,
    parameter int UNIT_W = 2,
    parameter int OP_W   = 6,
    parameter int TAG_W  = 4,
    parameter int VAL_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [UNIT_W-1:0]          in_unit,
    input  logic [OP_W-1:0]            in_op,
    input  logic [TAG_W-1:0]           in_tag1,
    input  logic [TAG_W-1:0]           in_tag2,
    input  logic [VAL_W-1:0]           in_val1,
    input  logic [VAL_W-1:0]           in_val2,
    input  logic [TAG_W-1:0]           in_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [UNIT_W-1:0]          out_unit,
    output logic [OP_W-1:0]            out_op,
    output logic [TAG_W-1:0]           out_tag1,
    output logic [TAG_W-1:0]           out_tag2,
    output logic [VAL_W-1:0]           out_val1,
    output logic [VAL_W-1:0]           out_val2,
    output logic [TAG_W-1:0]           out_target,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [VAL_W-1:0]           cdb_val,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [UNIT_W-1:0] unit_r   [DEPTH];
    logic [OP_W-1:0]   op_r     [DEPTH];
    logic [TAG_W-1:0]  tag1_r   [DEPTH];
    logic [TAG_W-1:0]  tag2_r   [DEPTH];
    logic [VAL_W-1:0]  val1_r   [DEPTH];
    logic [VAL_W-1:0]  val2_r   [DEPTH];
    logic [TAG_W-1:0]  target_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              enq_s;
    logic              deq_s;
    logic              in_hit1_s;
    logic              in_hit2_s;

    // Tag 0 means "value present", so it can never be a snoop match.
    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                     input logic             bvalid,
                                     input logic [TAG_W-1:0] btag);
        return bvalid && (tag == btag) && (tag != '0);
    endfunction

    function automatic logic is_occupied(input logic [PTR_W-1:0] idx,
                                         input logic [PTR_W-1:0] head,
                                         input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = idx - head;
        return CNT_W'(off) < cnt;
    endfunction

    assign in_ready  = (count_r < CNT_W'(DEPTH));
    assign out_valid = (count_r != '0);
    assign count     = count_r;
    assign enq_s     = in_valid & in_ready;
    assign deq_s     = out_valid & out_ready;
    assign in_hit1_s = cdb_hit(in_tag1, cdb_valid, cdb_tag);
    assign in_hit2_s = cdb_hit(in_tag2, cdb_valid, cdb_tag);
    assign out_unit   = unit_r[head_r];
    assign out_op     = op_r[head_r];
    assign out_target = target_r[head_r];

    // Head operand 1 with same-cycle CDB bypass
    always_comb begin
        if (cdb_hit(tag1_r[head_r], cdb_valid, cdb_tag)) begin
            out_tag1 = '0;
            out_val1 = cdb_val;
        end else begin
            out_tag1 = tag1_r[head_r];
            out_val1 = val1_r[head_r];
        end
    end

    // Head operand 2 with same-cycle CDB bypass
    always_comb begin
        if (cdb_hit(tag2_r[head_r], cdb_valid, cdb_tag)) begin
            out_tag2 = '0;
            out_val2 = cdb_val;
        end else begin
            out_tag2 = tag2_r[head_r];
            out_val2 = val2_r[head_r];
        end
    end

    // Pointers, occupancy, CDB snoop and entry writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                unit_r[i]   <= '0;
                op_r[i]     <= '0;
                tag1_r[i]   <= '0;
                tag2_r[i]   <= '0;
                val1_r[i]   <= '0;
                val2_r[i]   <= '0;
                target_r[i] <= '0;
            end
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (is_occupied(PTR_W'(i), head_r, count_r)) begin
                    if (cdb_hit(tag1_r[i], cdb_valid, cdb_tag)) begin
                        tag1_r[i] <= '0;
                        val1_r[i] <= cdb_val;
                    end
                    if (cdb_hit(tag2_r[i], cdb_valid, cdb_tag)) begin
                        tag2_r[i] <= '0;
                        val2_r[i] <= cdb_val;
                    end
                end
            end
            // The tail slot is free whenever enq_s is set, so this never races the snoop.
            if (enq_s) begin
                unit_r[tail_r]   <= in_unit;
                op_r[tail_r]     <= in_op;
                tag1_r[tail_r]   <= in_hit1_s ? '0 : in_tag1;
                val1_r[tail_r]   <= in_hit1_s ? cdb_val : in_val1;
                tag2_r[tail_r]   <= in_hit2_s ? '0 : in_tag2;
                val2_r[tail_r]   <= in_hit2_s ? cdb_val : in_val2;
                target_r[tail_r] <= in_target;
                tail_r           <= tail_r + PTR_W'(1);
            end
            if (deq_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: doc/idex_queue.md
# idex_queue

Parametrised decode-to-execute dispatch queue. It sits between instruction decode and the reservation stations. It buffers up to DEPTH decoded instructions with a valid/ready handshake on both sides. While an instruction waits, the queue snoops the common data bus (CDB) and captures operand values whose producer tag is broadcast. A flush discards all buffered entries on mispredict.

## Interface
Parameters:
- DEPTH, 4: entries; power of two, ≥2
- UNIT_W, 2: execution-unit select width
- OP_W, 6: opcode width
- TAG_W, 4: ROB tag width; tag value 0 means "operand value present"
- VAL_W, 32: operand width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  discard all entries
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  queue can accept
- in_unit  in  UNIT_W  target execution unit
- in_op  in  OP_W  opcode
- in_tag1, in_tag2  in  TAG_W  operand producer tags
- in_val1, in_val2  in  VAL_W  operand values (meaningful when tag is 0)
- in_target  in  TAG_W  destination ROB entry
- out_valid  out  1  head entry available
- out_ready  in  1  reservation station accepts
- out_unit, out_op, out_tag1, out_tag2, out_val1, out_val2, out_target  out  as in_*  head entry fields
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  TAG_W  broadcasting ROB tag (never 0 when cdb_valid)
- cdb_val  in  VAL_W  broadcast value
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer with head/tail pointers of width $clog2(DEPTH); pointers wrap DEPTH-1 → 0.
- Enqueue when in_valid & in_ready; dequeue when out_valid & out_ready.
- in_ready = (count < DEPTH). It is registered-state-only, with no combinational path from out_ready. Full with a simultaneous dequeue does not accept.
- out_valid = (count != 0). out_* come from the head entry, with the CDB bypass below applied.
- CDB snoop, per occupied entry and per operand: if cdb_valid and tag == cdb_tag and tag != 0, the entry stores val ← cdb_val and tag ← 0 at the clock edge.
- Enqueue bypass: if the incoming in_tagN matches the CDB in the same cycle, the entry is written with tag 0 and val cdb_val.
- Output bypass: if the head operand tag matches the CDB this cycle, out_tagN = 0 and out_valN = cdb_val combinationally. A dequeue in that cycle never loses the broadcast.
- Unmatched operands pass through unchanged. Entries with tag 0 are never overwritten by snoop.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- flush: head, tail and count go to 0 at the edge. Flush has priority over enqueue, dequeue and snoop. An in_valid in the flush cycle is dropped.
- Reset (async): head = tail = count = 0, all entry storage = 0.
  - Outputs during and after reset: out_valid 0, all out_* 0, count 0, in_ready 1.

## Timing
- Enqueue → out_valid latency: 1 cycle. An instruction written at edge N appears at out_* after edge N. There is no fall-through when empty.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained.
- count updates at the edge following the handshake.
- A CDB capture is visible on out_* for a buffered entry after the capture edge. For the head entry it is visible in the same cycle via the output bypass.
- Deassertion of flush: enqueue is accepted in the next cycle (in_ready = 1).

## Test plan
- Fill/drain: DEPTH=4, 4 back-to-back enqueues with out_ready=0 → count 4, in_ready 0. A 5th in_valid is not accepted. Then out_ready=1 for 4 cycles → entries emerge in order, count 0, out_valid 0.
- Wrap-around: 6 enqueues interleaved with dequeues (steady count 1–2) → pointers wrap past 3 and targets emerge in issue order 1..6.
- Buffered snoop: enqueue tag1=5 with out_ready=0, then cdb_valid tag 5 val 0xDEADBEEF → out_tag1 0 and out_val1 0xDEADBEEF. tag2=3 stays unchanged.
- Same-cycle bypasses, two cases:
  - Enqueue with in_tag2=7 while CDB broadcasts 7/0x1234 → entry stored with tag 0, val 0x1234.
  - Head tag1=2 dequeued while CDB broadcasts 2/0x55 → out_tag1 0, out_val1 0x55 in that cycle.
- Flush: count 3, then flush with in_valid=1 and out_ready=1 → next cycle count 0, out_valid 0, in_ready 1, and neither instruction is kept.
- Async reset mid-operation: count 2, assert rst between edges → out_valid 0, count 0 immediately. After release, the first enqueue appears 1 cycle later.
